// File: rtl/mult_div_unit_if.sv
// Operand, control and result bundle between the MIPS control/datapath and the
// multiply/divide unit; HI/LO and the handshake flags come back on the same bundle.
interface mult_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wr_data;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, hi_we, lo_we, wr_data,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, a, b, hi_we, lo_we, wr_data,
      output busy, done, div_by_zero, hi, lo
   );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers: shift-add multiply and
// restoring divide on operand magnitudes, one iteration per bit, sign fix-up at the end.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic            clk,
   input  logic            reset,
   mult_div_unit_if.slave  bus
);
   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t               state_r;
   state_t               next_state_s;
   logic [CNT_W-1:0]     cnt_r;
   logic [2*WIDTH:0]     acc_r;
   logic [WIDTH:0]       mag_b_r;
   logic                 op_div_r;
   logic                 neg_q_r;
   logic                 neg_r_r;
   logic                 busy_r;
   logic                 done_r;
   logic                 dbz_r;
   logic [WIDTH-1:0]     hi_r;
   logic [WIDTH-1:0]     lo_r;

   logic                 signed_op_s;
   logic                 sign_a_s;
   logic                 sign_b_s;
   logic [WIDTH-1:0]     mag_a_s;
   logic [WIDTH-1:0]     mag_b_s;
   logic                 div_zero_s;
   logic [WIDTH:0]       mul_upper_s;
   logic [2*WIDTH:0]     mul_next_s;
   logic [WIDTH:0]       div_shift_s;
   logic                 div_ge_s;
   logic [WIDTH:0]       div_rem_s;
   logic [2*WIDTH:0]     div_next_s;
   logic [2*WIDTH-1:0]   prod_fix_s;
   logic [WIDTH-1:0]     res_hi_s;
   logic [WIDTH-1:0]     res_lo_s;

   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.div_by_zero = dbz_r;
   assign bus.hi          = hi_r;
   assign bus.lo          = lo_r;

   // Operand magnitudes and the divide-by-zero shortcut decoded from the start request.
   always_comb begin
      signed_op_s = ~bus.op[0];
      sign_a_s    = signed_op_s & bus.a[WIDTH-1];
      sign_b_s    = signed_op_s & bus.b[WIDTH-1];
      if (sign_a_s) begin
         mag_a_s = {WIDTH{1'b0}} - bus.a;
      end else begin
         mag_a_s = bus.a;
      end
      if (sign_b_s) begin
         mag_b_s = {WIDTH{1'b0}} - bus.b;
      end else begin
         mag_b_s = bus.b;
      end
      div_zero_s = bus.op[1] & (bus.b == {WIDTH{1'b0}});
   end

   // One iteration of each algorithm; acc holds {upper partial, multiplier} or {remainder, quotient}.
   always_comb begin
      if (acc_r[0]) begin
         mul_upper_s = acc_r[2*WIDTH:WIDTH] + mag_b_r;
      end else begin
         mul_upper_s = acc_r[2*WIDTH:WIDTH];
      end
      mul_next_s  = {1'b0, mul_upper_s, acc_r[WIDTH-1:1]};
      div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
      div_ge_s    = (div_shift_s >= mag_b_r);
      if (div_ge_s) begin
         div_rem_s = div_shift_s - mag_b_r;
      end else begin
         div_rem_s = div_shift_s;
      end
      div_next_s  = {div_rem_s, acc_r[WIDTH-2:0], div_ge_s};
   end

   // Sign fix-up of the finished magnitude result.
   always_comb begin
      prod_fix_s = acc_r[2*WIDTH-1:0];
      res_hi_s   = acc_r[2*WIDTH-1:WIDTH];
      res_lo_s   = acc_r[WIDTH-1:0];
      if (op_div_r) begin
         if (neg_q_r) begin
            res_lo_s = {WIDTH{1'b0}} - acc_r[WIDTH-1:0];
         end else begin
            res_lo_s = acc_r[WIDTH-1:0];
         end
         if (neg_r_r) begin
            res_hi_s = {WIDTH{1'b0}} - acc_r[2*WIDTH-1:WIDTH];
         end else begin
            res_hi_s = acc_r[2*WIDTH-1:WIDTH];
         end
      end else begin
         if (neg_q_r) begin
            prod_fix_s = {(2*WIDTH){1'b0}} - acc_r[2*WIDTH-1:0];
         end else begin
            prod_fix_s = acc_r[2*WIDTH-1:0];
         end
         res_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
         res_lo_s = prod_fix_s[WIDTH-1:0];
      end
   end

   // Next-state logic; a divide by zero completes directly from IDLE.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.start && !div_zero_s) begin
               next_state_s = RUN;
            end else begin
               next_state_s = IDLE;
            end
         end
         RUN: begin
            if (cnt_r == CNT_W'(WIDTH - 1)) begin
               next_state_s = FIX;
            end else begin
               next_state_s = RUN;
            end
         end
         FIX:     next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Datapath, HI/LO and status registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r    <= {CNT_W{1'b0}};
         acc_r    <= {(2*WIDTH+1){1'b0}};
         mag_b_r  <= {(WIDTH+1){1'b0}};
         op_div_r <= 1'b0;
         neg_q_r  <= 1'b0;
         neg_r_r  <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         dbz_r    <= 1'b0;
         hi_r     <= {WIDTH{1'b0}};
         lo_r     <= {WIDTH{1'b0}};
      end else begin
         done_r <= 1'b0;
         dbz_r  <= 1'b0;
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  if (div_zero_s) begin
                     done_r <= 1'b1;
                     dbz_r  <= 1'b1;
                  end else begin
                     op_div_r <= bus.op[1];
                     neg_q_r  <= sign_a_s ^ sign_b_s;
                     neg_r_r  <= sign_a_s;
                     acc_r    <= {{(WIDTH+1){1'b0}}, mag_a_s};
                     mag_b_r  <= {1'b0, mag_b_s};
                     cnt_r    <= {CNT_W{1'b0}};
                     busy_r   <= 1'b1;
                  end
               end else begin
                  if (bus.hi_we) begin
                     hi_r <= bus.wr_data;
                  end
                  if (bus.lo_we) begin
                     lo_r <= bus.wr_data;
                  end
               end
            end
            RUN: begin
               acc_r <= op_div_r ? div_next_s : mul_next_s;
               cnt_r <= cnt_r + CNT_W'(1);
            end
            FIX: begin
               hi_r   <= res_hi_s;
               lo_r   <= res_lo_s;
               done_r <= 1'b1;
               busy_r <= 1'b0;
            end
            default: begin
               busy_r <= 1'b0;
            end
         endcase
      end
   end
endmodule
